// File: rtl/ddr_pkg.sv
// Shared constants and state encoding for the DDR power-up init sequencer.
package ddr_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESELECT = 4'b1111;
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_PRE      = 4'b0010;
  localparam logic [3:0] CMD_LMR      = 4'b0000;
  localparam logic [3:0] CMD_AREF     = 4'b0001;

  localparam logic [1:0]  BA_MR        = 2'b00;
  localparam logic [1:0]  BA_EMR       = 2'b01;
  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;
  localparam logic [12:0] MR_DLL_RESET = 13'h0100;

  // Sequence order matters: the FSM advances by incrementing the encoding.
  typedef enum logic [3:0] {
    ST_IDLE, ST_POWERUP, ST_CKE, ST_PRE1, ST_EMR, ST_MR1,
    ST_PRE2, ST_REF1, ST_REF2, ST_MR2, ST_SETTLE, ST_DONE
  } state_e;

endpackage

// File: rtl/ddr_init_timer.sv
// 16-bit loadable down-counter that holds at zero; paces the init sequence.
module ddr_init_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] value_i,
  output logic        zero_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt_q <= '0;
    else if (clr_i)           cnt_q <= '0;
    else if (load_i)          cnt_q <= value_i;
    else if (cnt_q != 16'd0)  cnt_q <= cnt_q - 16'd1;
  end

  assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/ddr_init_sequencer.sv
// JEDEC DDR power-up sequencer: waits for clock lock, walks CKE/PRE/LMR/AREF
// with per-step waits, then raises init_done. Lock loss restarts from IDLE.
module ddr_init_sequencer
  import ddr_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 20000,
  parameter int unsigned T_RP           = 3,
  parameter int unsigned T_MRD          = 2,
  parameter int unsigned T_RFC          = 8,
  parameter int unsigned DLL_CYCLES     = 200,
  parameter logic [12:0] MODE_REG       = 13'h021,
  parameter logic [12:0] EXT_MODE_REG   = 13'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_ok,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        init_done
);

  logic        sync1_q, ok_s_q;
  state_e      state_q, state_d;
  logic        cke_q, cke_d, done_q, done_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] addr_q, addr_d;
  logic        entering, preinit, tmr_clr, tmr_zero;
  logic [15:0] tmr_val;

  // Time spent in a state before moving on.
  function automatic logic [15:0] wait_of(input state_e s);
    case (s)
      ST_POWERUP:                   return 16'(POWERUP_CYCLES);
      ST_CKE, ST_PRE1, ST_PRE2:     return 16'(T_RP);
      ST_EMR, ST_MR1, ST_MR2:       return 16'(T_MRD);
      ST_REF1, ST_REF2:             return 16'(T_RFC);
      ST_SETTLE:                    return 16'(DLL_CYCLES);
      default:                      return 16'd1;
    endcase
  endfunction

  ddr_init_timer u_timer (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (tmr_clr),
    .load_i  (entering),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    entering = 1'b0;
    tmr_clr  = 1'b0;
    if (!ok_s_q) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_POWERUP;
          entering = 1'b1;
        end
        ST_DONE: state_d = ST_DONE;
        default: if (tmr_zero) begin
          state_d  = state_e'(state_q + 4'd1);
          entering = 1'b1;
        end
      endcase
    end
    tmr_val = wait_of(state_d) - 16'd1;

    // Outputs are registered from the next state; commands fire only on entry.
    preinit = (state_d == ST_IDLE) || (state_d == ST_POWERUP);
    cke_d   = !preinit;
    cmd_d   = preinit ? CMD_DESELECT : CMD_NOP;
    ba_d    = 2'b00;
    addr_d  = 13'h0;
    done_d  = (state_d == ST_DONE);
    if (entering) begin
      case (state_d)
        ST_PRE1, ST_PRE2: begin
          cmd_d  = CMD_PRE;
          addr_d = ADDR_PRE_ALL;
        end
        ST_EMR: begin
          cmd_d  = CMD_LMR;
          ba_d   = BA_EMR;
          addr_d = EXT_MODE_REG;
        end
        ST_MR1: begin
          cmd_d  = CMD_LMR;
          ba_d   = BA_MR;
          addr_d = MODE_REG | MR_DLL_RESET;
        end
        ST_MR2: begin
          cmd_d  = CMD_LMR;
          ba_d   = BA_MR;
          addr_d = MODE_REG & ~MR_DLL_RESET;
        end
        ST_REF1, ST_REF2: cmd_d = CMD_AREF;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      ok_s_q  <= 1'b0;
      state_q <= ST_IDLE;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_DESELECT;
      ba_q    <= 2'b00;
      addr_q  <= 13'h0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= clk_ok;
      ok_s_q  <= sync1_q;
      state_q <= state_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign cke       = cke_q;
  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign ba        = ba_q;
  assign addr      = addr_q;
  assign init_done = done_q;

endmodule
